// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: arbiter FSM states and
// mul_op codes common to mul_arbiter and mul_unit.
`ifndef XLEN
`define XLEN 32
`endif
package mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

endpackage

// File: rtl/mul_unit.sv
// Fixed-latency multi-cycle multiplier: latches the result on start,
// pulses ready LAT cycles later. Start while busy is ignored.
`ifndef XLEN
`define XLEN 32
`endif
module mul_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = `XLEN,
  parameter int LAT  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy
);

  localparam logic [3:0] LAT_C = 4'(LAT);

  logic              sa, sb;
  logic [2*XLEN-1:0] ea, eb, p;
  logic [XLEN-1:0]   r, res_q, res_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;

  always_comb begin
    sa = (op == MULH) || (op == MULHSU);
    sb = (op == MULH);
    // Low 2*XLEN bits of the product of sign-extended operands are exact.
    ea = {{XLEN{sa & a[XLEN-1]}}, a};
    eb = {{XLEN{sb & b[XLEN-1]}}, b};
    p  = ea * eb;
    r  = (op == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    if (word) begin
      for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? p[i] : p[31];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    rdy_d = 1'b0;
    if (start && cnt_q == 4'd0) begin
      cnt_d = LAT_C;
      res_d = r;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      rdy_d = (cnt_q == 4'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      res_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      res_q <= res_d;
      rdy_q <= rdy_d;
    end
  end

  assign result = res_q;
  assign ready  = rdy_q;
  assign busy   = (cnt_q != 4'd0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone eligible requester wins outright,
// a tie goes to prio and hands priority to the other side.
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       prio_nxt
);

  always_comb begin
    gnt      = elig;
    prio_nxt = prio;
    if (&elig) begin
      gnt      = prio ? 2'b10 : 2'b01;
      prio_nxt = ~prio;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for mul_unit: one op in flight,
// tagged responses with backpressure, per-requester flush.
`ifndef XLEN
`define XLEN 32
`endif
module mul_arbiter
  import mdu_pkg::*;
#(
  parameter int XLEN  = `XLEN,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op,
  input  logic [1:0]           req_word,
  input  logic [2*XLEN-1:0]    req_a,
  input  logic [2*XLEN-1:0]    req_b,
  input  logic [2*TAG_W-1:0]   req_tag,
  input  logic [1:0]           flush,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic [TAG_W-1:0]     resp_tag,
  output logic                 mul_start,
  output logic [1:0]           mul_op,
  output logic                 mul_word,
  output logic [XLEN-1:0]      mul_a,
  output logic [XLEN-1:0]      mul_b,
  input  logic [XLEN-1:0]      mul_result,
  input  logic                 mul_ready,
  input  logic                 mul_busy,
  output logic                 arb_busy
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d, owner_q, owner_d, killed_q, killed_d;
  logic              start_q, start_d, word_q, word_d, kill_now;
  logic [1:0]        op_q, op_d, elig, gnt;
  logic              prio_nxt, g;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  // Flush beats a simultaneous req_valid; req_ready stays low during reset.
  assign elig = (state_q == S_IDLE && !mul_busy && !reset) ? (req_valid & ~flush) : 2'b00;
  assign g    = gnt[1];

  rr_arb2 u_rr (.elig(elig), .prio(prio_q), .gnt(gnt), .prio_nxt(prio_nxt));

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    killed_d = killed_q;
    op_d     = op_q;
    word_d   = word_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    data_d   = data_q;
    kill_now = killed_q | flush[owner_q];
    case (state_q)
      S_IDLE: if (|gnt) begin
        state_d  = S_ISSUE;
        prio_d   = prio_nxt;
        owner_d  = g;
        killed_d = 1'b0;
        op_d     = g ? req_op[3:2] : req_op[1:0];
        word_d   = req_word[g];
        a_d      = g ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
        b_d      = g ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
        tag_d    = g ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
      end
      S_ISSUE: begin
        state_d  = S_WAIT;
        killed_d = kill_now;
      end
      // A killed op still drains through mul_unit; its result is dropped.
      S_WAIT: begin
        killed_d = kill_now;
        if (mul_ready) begin
          if (kill_now) state_d = S_IDLE;
          else begin
            data_d  = mul_result;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: if (flush[owner_q] || resp_ready[owner_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      killed_q <= 1'b0;
      start_q  <= 1'b0;
      op_q     <= '0;
      word_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      start_q  <= start_d;
      op_q     <= op_d;
      word_q   <= word_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

  assign req_ready  = gnt;
  assign resp_valid = (state_q == S_RESP && !flush[owner_q]) ? {owner_q, ~owner_q} : 2'b00;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign mul_start  = start_q;
  assign mul_op     = op_q;
  assign mul_word   = word_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign arb_busy   = (state_q != S_IDLE);

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-requester arbiter and sequencer for the shared iterative multiplier (`mul_unit`). It accepts MUL/MULH/MULHSU/MULHU requests from two sources, such as the integer pipeline EX stage and a second issue port. It grants them round-robin, sequences `mul_unit` through its start/ready handshake with one operation in flight, and returns tagged results with valid/ready backpressure. Per-requester flush kills queued or in-flight work without aborting the multiplier.

## Interface
- `XLEN`, default `` `XLEN ``: operand/result width (32 or 64).
- `TAG_W`, default 4: width of the per-request tag returned with the result.

- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 2: request pending, one bit per requester.
- `req_ready` out 2: request accepted this cycle (one-hot or zero).
- `req_op` in 4: `mul_op` per requester, [1:0]=req0, [3:2]=req1.
- `req_word` in 2: RV64 W-op flag per requester.
- `req_a`, `req_b` in 2*XLEN each: operands, low half = req0.
- `req_tag` in 2*TAG_W: tag, low field = req0.
- `flush` in 2: kill all work of that requester.
- `resp_valid` out 2: result valid for that requester (one-hot or zero).
- `resp_ready` in 2: requester consumes the result.
- `resp_data` out XLEN: result.
- `resp_tag` out TAG_W: result tag.
- `mul_start` out 1: start pulse to `mul_unit`.
- `mul_op` out 2: operation to `mul_unit`.
- `mul_word` out 1: W-op flag to `mul_unit`.
- `mul_a`, `mul_b` out XLEN: operands to `mul_unit`.
- `mul_result` in XLEN: result from `mul_unit`.
- `mul_ready` in 1: one-cycle result pulse from `mul_unit`.
- `mul_busy` in 1: `mul_unit` not idle.
- `arb_busy` out 1: arbiter not in S_IDLE.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
- **S_IDLE.** Eligible requesters are those with `req_valid` high and `flush` low. Grant only if `mul_busy`=0.
  - One eligible: grant it.
  - Both eligible: grant the requester selected by `prio`, then set `prio` to the other requester.
  - A single grant leaves `prio` unchanged.
  - On grant: pulse `req_ready[g]`, latch op, word flag, a, b, tag and owner=g; go to S_ISSUE.
- **S_ISSUE.** Drive `mul_start`=1 with the latched op, word flag and operands (all registered). Go to S_WAIT unconditionally.
- **S_WAIT.** Wait for `mul_ready`; the arbiter assumes no fixed multiplier latency.
  - On `mul_ready` with `killed`=0: capture `mul_result` into `resp_data` and go to S_RESP.
  - On `mul_ready` with `killed`=1: discard the result and go to S_IDLE.
- **S_RESP.** Assert `resp_valid[owner]` and hold `resp_data` and `resp_tag` stable until `resp_ready[owner]`, then go to S_IDLE.
- **Flush.**
  - `flush[owner]` in S_ISSUE or S_WAIT sets `killed`. The operation still runs to completion, because `mul_unit` cannot abort.
  - `flush[owner]` in S_RESP drops `resp_valid` the same cycle and the next state is S_IDLE.
  - `flush` of the non-owner does not affect the in-flight operation.
  - In S_IDLE, a flushed requester is not eligible that cycle. Flush wins over a simultaneous `req_valid`.
- `mul_ready` seen outside S_WAIT is ignored.
- `mul_op`, `mul_word`, `mul_a` and `mul_b` hold their latched values outside S_ISSUE.
- `killed` clears on every grant.
- **Reset values:**
  - state=S_IDLE, `prio`=0, owner=0, `killed`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_tag`=0.
  - `mul_start`=0, `mul_op`=0, `mul_word`=0, `mul_a`=0, `mul_b`=0.
  - `arb_busy`=0.
- Reset mid-operation: the arbiter returns to S_IDLE at once. Top level drives `mul_unit` `reset_n` = ~`reset`, so both restart together and no stale `mul_ready` follows.

## Timing
- Grant in cycle N: `req_ready` is combinational in cycle N, and `mul_start` is high for exactly cycle N+1.
- `mul_ready` in cycle M: `resp_valid` is high from cycle M+1.
- Response consumed in cycle R: earliest next grant is R+1. The arbiter never grants in the same cycle as a response handshake.
- At most one operation is outstanding. `req_ready` is 0 in every state except S_IDLE.
- `arb_busy` = (state != S_IDLE), combinational.

## Structure
- Shared package/header `mdu_pkg`:
  - state encodings (S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT=2'd2, S_RESP=2'd3);
  - mul op encodings (MUL=00, MULH=01, MULHSU=10, MULHU=11), shared with `mul_unit`.
- Natural sub-module: `rr_arb2`, the combinational 2-way round-robin pick plus `prio` register update (inputs: eligible[1:0], prio; outputs: grant one-hot, next prio).
- All other logic stays flat in `mul_arbiter`.
- Bench instantiates the real `mul_unit` behind the arbiter.

## Test plan
- **Single request.** req0 MUL a=7, b=-3, tag=5 (XLEN=32).
  - `mul_start` is high exactly one cycle after `req_ready[0]`.
  - `resp_valid[0]` returns `resp_data`=0xFFFFFFEB, tag=5.
- **Contention.** Both requesters valid every cycle from reset.
  - Grant order is 0, 1, 0, 1.
  - Each requester receives only its own tags, each once.
- **Backpressure.** Hold `resp_ready[1]` low for 10 cycles with a MULHU 0xFFFFFFFF×0xFFFFFFFF result.
  - `resp_data`=0xFFFFFFFE stays stable throughout.
  - No grant occurs while held.
- **Flush in flight.** Assert `flush[0]` during S_WAIT.
  - `resp_valid[0]` never asserts.
  - Next grant happens only after `mul_ready`.
  - A pending req1 is then served with the correct result.
- **Flush priority.** `flush[1]` together with `req_valid[1]` in S_IDLE with req0 idle: no grant that cycle. Flush during S_RESP: `resp_valid` drops the same cycle.
- **Reset.** Assert `reset` during S_WAIT: every output reads its reset value immediately. A new request after reset completes normally.
